// File: rtl/cla_pkg.sv
// Shared constants, stage-partitioning helpers and the pipeline payload type
// for the pipelined carry-lookahead adder.
package cla_pkg;

   localparam int GROUP     = 32'sd4;
   localparam int MAX_WIDTH = 32'sd64;

   typedef struct packed {
      logic [MAX_WIDTH-1:0] sum;
      logic [MAX_WIDTH-1:0] a;
      logic [MAX_WIDTH-1:0] b;
      logic                 carry;
      logic                 ovf;
      logic                 valid;
   } payload_t;

   // Groups handled by compute stage k; the remainder lands in the last stage.
   function automatic int groups_in_stage(input int n_groups, input int n_stages, input int k);
      int base;
      base = n_groups / n_stages;
      if (k == n_stages - 32'sd1) begin
         groups_in_stage = base + (n_groups % n_stages);
      end else begin
         groups_in_stage = base;
      end
   endfunction

   function automatic int first_group(input int n_groups, input int n_stages, input int k);
      first_group = k * (n_groups / n_stages);
   endfunction

   function automatic int stage_of_group(input int n_groups, input int n_stages, input int g);
      int k;
      k = g / (n_groups / n_stages);
      if (k > n_stages - 32'sd1) begin
         stage_of_group = n_stages - 32'sd1;
      end else begin
         stage_of_group = k;
      end
   endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle of the pipelined adder; the master side
// offers operands and consumes results.
interface cla_adder_pipe_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             Ovf;

   modport master (
      output in_valid, A, B, Cin, sub, out_ready,
      input  in_ready, out_valid, S, Cout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, sub, out_ready,
      output in_ready, out_valid, S, Cout, Ovf
   );

endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group. pg/gg expose the group
// propagate/generate terms for a second lookahead level.
module cla_group4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       pg,
   output logic       gg
);

   logic [3:0] g_s;
   logic [3:0] p_s;
   logic [4:0] c_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   assign c_s[0] = ci;
   assign c_s[1] = g_s[0] | (p_s[0] & ci);
   assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
   assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & ci);
   assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                 | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

   assign gg = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
   assign pg = &p_s;
   assign co = c_s[4];
   assign s  = p_s ^ c_s[3:0];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 0 captures operands; compute stages resolve slices of 4-bit groups.
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   cla_adder_pipe_if.slave bus
);

   localparam int N_GROUPS = WIDTH / GROUP;

   payload_t         pipe_r [0:STAGES];
   payload_t         in_s;
   logic             stall_s;
   logic [WIDTH-1:0] grp_sum_s;

   // A stalled output freezes every register, so in_ready drops with it.
   assign stall_s       = pipe_r[STAGES].valid && !bus.out_ready;
   assign bus.in_ready  = !stall_s && !rst;
   assign bus.out_valid = pipe_r[STAGES].valid;
   assign bus.S         = pipe_r[STAGES].sum[WIDTH-1:0];
   assign bus.Cout      = pipe_r[STAGES].carry;
   assign bus.Ovf       = pipe_r[STAGES].ovf;

   // Operand conditioning: subtraction is A + ~B + 1.
   always_comb begin
      in_s                = '0;
      in_s.a[WIDTH-1:0]   = bus.A;
      in_s.valid          = bus.in_valid;
      if (bus.sub) begin
         in_s.b[WIDTH-1:0] = ~bus.B;
         in_s.carry        = 1'b1;
      end else begin
         in_s.b[WIDTH-1:0] = bus.B;
         in_s.carry        = bus.Cin;
      end
   end

   // Input register stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_r[0] <= '0;
      end else if (!stall_s) begin
         pipe_r[0] <= in_s;
      end else begin
         pipe_r[0] <= pipe_r[0];
      end
   end

   for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
      localparam int K = stage_of_group(N_GROUPS, STAGES, g);
      logic ci_s;
      logic co_s;
      logic pg_s;
      logic gg_s;

      if (g == first_group(N_GROUPS, STAGES, K)) begin : g_head
         assign ci_s = pipe_r[K].carry;
      end else begin : g_chain
         assign ci_s = g_grp[g-1].co_s;
      end

      cla_group4 u_grp (
         .a  (pipe_r[K].a[g*GROUP +: GROUP]),
         .b  (pipe_r[K].b[g*GROUP +: GROUP]),
         .ci (ci_s),
         .s  (grp_sum_s[g*GROUP +: GROUP]),
         .co (co_s),
         .pg (pg_s),
         .gg (gg_s)
      );
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int FG   = first_group(N_GROUPS, STAGES, k);
      localparam int NG   = groups_in_stage(N_GROUPS, STAGES, k);
      localparam int LO   = FG * GROUP;
      localparam int NB   = NG * GROUP;
      localparam int LAST = FG + NG - 1;
      payload_t nxt_s;

      // Merge this slice's sum bits; only the final slice can judge overflow.
      always_comb begin
         nxt_s               = pipe_r[k];
         nxt_s.sum[LO +: NB] = grp_sum_s[LO +: NB];
         nxt_s.carry         = g_grp[LAST].co_s;
         if (k == STAGES - 1) begin
            nxt_s.ovf = g_grp[LAST].co_s ^ grp_sum_s[WIDTH-1]
                      ^ pipe_r[k].a[WIDTH-1] ^ pipe_r[k].b[WIDTH-1];
         end else begin
            nxt_s.ovf = 1'b0;
         end
      end

      // Compute-stage register.
      always_ff @(posedge clk) begin
         if (rst) begin
            pipe_r[k+1] <= '0;
         end else if (!stall_s) begin
            pipe_r[k+1] <= nxt_s;
         end else begin
            pipe_r[k+1] <= pipe_r[k+1];
         end
      end
   end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench: three adder configurations (4/1, 16/2, 32/3), an
// arithmetic reference model, and per-instance output monitors.
module tb_cla_adder_pipe;

   localparam int W_TAB  [3] = '{4, 16, 32};
   localparam int ST_TAB [3] = '{1, 2, 3};

   typedef struct {
      int          dut;
      logic [63:0] s;
      bit          cout;
      bit          ovf;
      bit          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic out_ready_i = 1'b1;
   logic [2:0]       in_valid_i = '0;
   logic [2:0]       cin_i = '0;
   logic [2:0]       sub_i = '0;
   logic [2:0][63:0] a_i = '0;
   logic [2:0][63:0] b_i = '0;
   logic [2:0]       in_ready_o, out_valid_o, cout_o, ovf_o;
   logic [2:0][63:0] s_o;

   exp_t exp_q [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   rmode = 0;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input int d, input logic [63:0] a, input logic [63:0] b,
                                  input bit cin, input bit sub);
      exp_t   e;
      longint m, ua, ub, t, sa, sb, r;
      m  = longint'(1) << W_TAB[d];
      ua = longint'(a) & (m - 1);
      ub = longint'(b) & (m - 1);
      if (sub) begin
         t      = ua - ub;
         e.cout = (ua >= ub);
      end else begin
         t      = ua + ub + longint'(cin);
         e.cout = (t >= m);
      end
      e.s = 64'(t & (m - 1));
      sa  = (ua >= m / 2) ? ua - m : ua;
      sb  = (ub >= m / 2) ? ub - m : ub;
      r   = sub ? (sa - sb) : (sa + sb + longint'(cin));
      e.ovf = (r > m / 2 - 1) || (r < -(m / 2));
      e.dut = d;
      e.lat = 1'b0;
      e.acc = 0;
      return e;
   endfunction

   for (genvar d = 0; d < 3; d++) begin : g_dut
      localparam int W  = W_TAB[d];
      localparam int ST = ST_TAB[d];

      cla_adder_pipe_if #(.WIDTH(W)) bus ();

      assign bus.in_valid  = in_valid_i[d];
      assign bus.A         = a_i[d][W-1:0];
      assign bus.B         = b_i[d][W-1:0];
      assign bus.Cin       = cin_i[d];
      assign bus.sub       = sub_i[d];
      assign bus.out_ready = out_ready_i;
      assign in_ready_o[d]  = bus.in_ready;
      assign out_valid_o[d] = bus.out_valid;
      assign s_o[d]         = 64'(bus.S);
      assign cout_o[d]      = bus.Cout;
      assign ovf_o[d]       = bus.Ovf;

      cla_adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      initial begin : mon
         logic       held_v;
         logic [W+1:0] held;
         exp_t       e;
         held_v = 1'b0;
         forever begin
            @(negedge clk);
            chk("in_ready", 64'(in_ready_o[d]),
                64'(!rst && !(out_valid_o[d] && !out_ready_i)));
            if (rst) begin
               held_v = 1'b0;
            end else begin
               if (held_v) begin
                  chk("hold_valid", 64'(out_valid_o[d]), 64'd1);
                  chk("hold_data", 64'({bus.S, bus.Cout, bus.Ovf}), 64'(held));
               end
               if (out_valid_o[d] && out_ready_i) begin
                  if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                     chk("spurious_beat", 64'(out_valid_o[d]), 64'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("S", s_o[d], e.s);
                     chk("Cout", 64'(cout_o[d]), 64'(e.cout));
                     chk("Ovf", 64'(ovf_o[d]), 64'(e.ovf));
                     if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(ST));
                  end
                  held_v = 1'b0;
               end else if (out_valid_o[d]) begin
                  held_v = 1'b1;
                  held   = {bus.S, bus.Cout, bus.Ovf};
               end else begin
                  held_v = 1'b0;
               end
            end
         end
      end
   end

   // out_ready pattern: 0 = always, 1 = one on / two off, 2 = random
   initial begin : ready_gen
      int k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            1:       out_ready_i = (k % 3 == 0);
            2:       out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'b1;
         endcase
         k++;
      end
   end

   task automatic send(input int d, input logic [63:0] a, input logic [63:0] b,
                       input bit cin, input bit sub, input bit lat);
      exp_t e;
      bit   done;
      done = 1'b0;
      a_i[d] = a; b_i[d] = b; cin_i[d] = cin; sub_i[d] = sub;
      in_valid_i[d] = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready_o[d]) begin
            e     = model(d, a, b, cin, sub);
            e.lat = lat;
            e.acc = cyc + 1;
            exp_q.push_back(e);
            done  = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid_i[d] = 1'b0;
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: dut %0d never ready", d);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      bit empty;
      empty = 1'b0;
      for (int i = 0; i < 500 && !empty; i++) begin
         @(negedge clk);
         empty = (exp_q.size() == 0);
      end
      if (!empty) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (3) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            chk("rst_out_valid", 64'(out_valid_o[d]), 64'd0);
            chk("rst_S", s_o[d], 64'd0);
            chk("rst_Cout", 64'(cout_o[d]), 64'd0);
            chk("rst_Ovf", 64'(ovf_o[d]), 64'd0);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk("ready_after_rst", 64'(in_ready_o[d]), 64'd1);
      @(posedge clk); #1;

      // 4-bit, single stage
      send(0, 64'hF, 64'hF, 1'b1, 1'b0, 1'b1);
      send(0, 64'hA, 64'hC, 1'b1, 1'b0, 1'b1);
      drain();

      // 16-bit, two stages: carry ripple, overflow, subtraction
      send(1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 1'b1);
      send(1, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b1);
      send(1, 64'h0005, 64'h0007, 1'b1, 1'b1, 1'b1);
      send(1, 64'h8000, 64'h0001, 1'b0, 1'b1, 1'b1);
      drain();

      // Back-pressure, 1-on/2-off
      rmode = 1;
      for (int i = 0; i < 8; i++) send(1, 64'(i), 64'(i * 3), 1'b0, 1'b0, 1'b0);
      drain();
      rmode = 0;
      idle(2);

      // Reset with two beats in flight
      send(1, 64'h1234, 64'h1111, 1'b0, 1'b0, 1'b0);
      send(1, 64'h4321, 64'h2222, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_out_valid", 64'(out_valid_o[1]), 64'd0);
      end
      @(posedge clk); #1;
      send(1, 64'h00FF, 64'h0F01, 1'b1, 1'b0, 1'b1);
      drain();

      // Random traffic, 32-bit, three stages
      rmode = 2;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            send(2, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         end else begin
            idle(1);
         end
      end
      rmode = 0;
      drain();
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
